// File: rtl/nios_system_myip_cpu_cpu_mult_combine.sv
// Final combine stage of the 32x32 multiplier: merges three 16x16 partial products
// into the low 32 bits of the product and carries valid/dst down to writeback.
module nios_system_myip_cpu_cpu_mult_combine #(
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  input  logic        M_mul_valid,
  input  logic [4:0]  M_mul_dst,
  input  logic        M_en,
  input  logic        M_flush,
  output logic [31:0] W_mul_result,
  output logic        W_mul_valid,
  output logic [4:0]  W_mul_dst,
  output logic [15:0] W_mul_count
);

  // Only the low halves of the cross products reach bits [31:16] of the result.
  logic [15:0] mid_in;
  logic        unused_cross_hi;
  assign mid_in          = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign unused_cross_hi = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  logic [31:0] w_src_result;
  logic        w_src_valid;
  logic [4:0]  w_src_dst;

  generate
    if (PIPE_STAGES == 1) begin : g_one_stage
      always_comb begin
        w_src_result = M_mul_cell_p1 + {mid_in, 16'h0000};
        w_src_valid  = M_mul_valid;
        w_src_dst    = M_mul_dst;
      end
    end else begin : g_two_stage
      logic [31:0] a_p1;
      logic [15:0] a_mid;
      logic        a_valid;
      logic [4:0]  a_dst;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          a_p1    <= '0;
          a_mid   <= '0;
          a_valid <= 1'b0;
          a_dst   <= '0;
        end else if (M_flush) begin
          a_valid <= 1'b0;
        end else if (M_en) begin
          a_p1    <= M_mul_cell_p1;
          a_mid   <= mid_in;
          a_valid <= M_mul_valid;
          a_dst   <= M_mul_dst;
        end
      end

      always_comb begin
        w_src_result = a_p1 + {a_mid, 16'h0000};
        w_src_valid  = a_valid;
        w_src_dst    = a_dst;
      end
    end
  endgenerate

  logic [31:0] w_result;
  logic        w_valid;
  logic [4:0]  w_dst;
  logic [15:0] w_count;

  // Flush kills the valid bits only; the retire counter keeps its history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_result <= '0;
      w_valid  <= 1'b0;
      w_dst    <= '0;
      w_count  <= '0;
    end else if (M_flush) begin
      w_valid <= 1'b0;
    end else if (M_en) begin
      w_result <= w_src_result;
      w_valid  <= w_src_valid;
      w_dst    <= w_src_dst;
      if (w_src_valid) begin
        w_count <= w_count + 16'd1;
      end
    end
  end

  assign W_mul_result = w_result;
  assign W_mul_valid  = w_valid;
  assign W_mul_dst    = w_dst;
  assign W_mul_count  = w_count;

endmodule

// File: doc/nios_system_myip_cpu_cpu_mult_combine.md
NIOS_SYSTEM_MYIP_CPU_CPU_MULT_COMBINE -- requirements
Module: nios_system_myIP_cpu_cpu_mult_combine

Interface
REQ-001 Parameter: PIPE_STAGES, default 2, number of register stages between partial-product inputs and result (legal values 1 or 2).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: M_mul_cell_p1  input  32  partial product src1[15:0]*src2[15:0], registered upstream.
REQ-005 Port: M_mul_cell_p2  input  32  partial product src1[15:0]*src2[31:16].
REQ-006 Port: M_mul_cell_p3  input  32  partial product src1[31:16]*src2[15:0].
REQ-007 Port: M_mul_valid  input  1  partial products on inputs belong to a live multiply instruction.
REQ-008 Port: M_mul_dst  input  5  destination register index travelling with the multiply.
REQ-009 Port: M_en  input  1  pipeline advance enable; 0 = stall, all stages hold.
REQ-010 Port: M_flush  input  1  kill all in-flight multiplies.
REQ-011 Port: W_mul_result  output  32  low 32 bits of the unsigned/two's-complement product.
REQ-012 Port: W_mul_valid  output  1  W_mul_result and W_mul_dst are valid this cycle.
REQ-013 Port: W_mul_dst  output  5  destination register index aligned with W_mul_result.
REQ-014 Port: W_mul_count  output  16  count of multiplies retired since reset.

Function
REQ-015 Combine rule: mid[15:0] = p2[15:0] + p3[15:0] (carry out discarded); result = p1 + {mid, 16'h0000}, modulo 2^32; bits p2/p3[31:16] shall not influence the result.
REQ-016 PIPE_STAGES=2: stage A registers p1 (32 b), mid (16 b), valid, dst; stage W registers the final sum, valid, dst.
REQ-017 PIPE_STAGES=1: single register stage computes full result from inputs directly.
REQ-018 Latency: result appears on W_* exactly PIPE_STAGES enabled (M_en=1) clock edges after inputs are sampled; stalled cycles add no latency beyond their own count.
REQ-019 When M_en=0 and M_flush=0, every stage register (data, valid, dst) shall hold its value.
REQ-020 When M_en=1, each stage loads from its predecessor; M_mul_valid=0 at input propagates as a bubble (valid=0); data registers of a bubble may load but W_mul_result is don't-care when W_mul_valid=0.
REQ-021 M_flush=1 on a clock edge shall clear all stage valid bits to 0, regardless of M_en; flush takes priority over advance and stall.
REQ-022 Input sampled in the same cycle as M_flush=1 shall be discarded (never retires).
REQ-023 W_mul_count increments by 1 on each edge where stage W is loaded with valid=1 (M_en=1, M_flush=0, predecessor valid=1); wraps 16'hFFFF -> 16'h0000 without saturating.
REQ-024 W_mul_count shall not be cleared by M_flush.
REQ-025 Back-to-back multiplies (M_mul_valid=1 every enabled cycle) shall retire one per enabled cycle with no bubbles.
REQ-026 All outputs shall be driven directly from registers (no combinational path input -> output).

Reset
REQ-027 reset=1 shall asynchronously force all valid bits to 0, W_mul_result to 32'h0, W_mul_dst to 5'h0, W_mul_count to 16'h0, internal p1/mid registers to 0.
REQ-028 Reset asserted mid-operation shall discard all in-flight multiplies; no retirement occurs in the first enabled edge after deassertion unless new valid input is presented.
REQ-029 Deassertion is synchronised externally; the block shall need no clock edges while reset is high.

Verification
REQ-030 Basic: p1=32'h00000008, p2=32'h00000006, p3=32'h00000004, valid=1, dst=5'd7, M_en=1 (PIPE_STAGES=2) -> 2 edges later W_mul_valid=1, W_mul_result=32'h000A0008, W_mul_dst=7, W_mul_count=1.
REQ-031 Wrap: p1=p2=p3=32'hFFFE0001 (operands 32'hFFFFFFFF each) -> W_mul_result=32'h00000001.
REQ-032 Stall: issue a multiply, hold M_en=0 for 3 cycles after first edge -> W_mul_valid stays 0 and stage contents unchanged; retires on the 2nd enabled edge with correct value, count increments once.
REQ-033 Flush: two multiplies in flight, M_flush=1 with M_en=0 -> next cycle all valids 0, no retirement, W_mul_count unchanged.
REQ-034 Throughput: 20 back-to-back random operand sets -> 20 consecutive retirements, each equal to (src1*src2) mod 2^32, dst in order, count=20.
REQ-035 Reset mid-flight: assert reset with stage A valid -> outputs zero immediately (asynchronously); after release with no new input, W_mul_valid remains 0.
